alu_compare_seq: RTL and testbench

- Parametrised, sequential magnitude/equality comparator for the ALU datapath.
- Compares two WIDTH-bit operands, signed or unsigned, one CHUNK-bit slice per cycle, starting at the most significant slice.
- Stops early at the first slice where the operands differ.
- Uses valid/ready handshakes on input and output, and keeps the existing 4-bit opcode result convention (answer in outp[0], outp[3:1] zero). Adds GE/LE opcodes and a signed mode.

---
 rtl/alu_compare_seq.sv | 141 ++++++++++++++
 tb/tb_alu_compare_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_compare_seq.sv
// Sequential magnitude/equality comparator. It walks the operands from the most significant CHUNK-bit slice down to the least.
// Latency: the result is valid m edges after accept, where m is the number of slices examined (1..NCHUNK).
// Backpressure: while the result is not taken, DONE holds the result and keeps in_ready low.
module alu_compare_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       outp,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [3:0] OP_EQ = 4'b1001;
    localparam logic [3:0] OP_NE = 4'b1011;
    localparam logic [3:0] OP_GT = 4'b1101;
    localparam logic [3:0] OP_LT = 4'b1111;
    localparam logic [3:0] OP_GE = 4'b1100;
    localparam logic [3:0] OP_LE = 4'b1110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;

    // Map the relation flags onto the requested opcode. Unknown opcodes answer 0.
    function automatic logic op_result(input logic [3:0] op, input logic e,
                                       input logic g, input logic l);
        logic r;
        case (op)
            OP_EQ:   r = e;
            OP_NE:   r = ~e;
            OP_GT:   r = g;
            OP_LT:   r = l;
            OP_GE:   r = g | e;
            OP_LE:   r = l | e;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Select the slice currently addressed by idx from both captured operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            outp      <= '0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bit maps two's-complement order onto unsigned order.
                        a_q   <= {A[WIDTH-1] ^ sgn, A[WIDTH-2:0]};
                        b_q   <= {B[WIDTH-1] ^ sgn, B[WIDTH-2:0]};
                        op_q  <= Op;
                        idx   <= IDXW'(NCHUNK - 1);
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_sl > b_sl) begin
                        gt        <= 1'b1;
                        outp      <= {3'b000, op_result(op_q, 1'b0, 1'b1, 1'b0)};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (a_sl < b_sl) begin
                        lt        <= 1'b1;
                        outp      <= {3'b000, op_result(op_q, 1'b0, 1'b0, 1'b1)};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (idx == '0) begin
                        eq        <= 1'b1;
                        outp      <= {3'b000, op_result(op_q, 1'b1, 1'b0, 1'b0)};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outp      <= '0;
                        eq        <= 1'b0;
                        gt        <= 1'b0;
                        lt        <= 1'b0;
                        out_valid <= 1'b0;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_compare_seq.sv
// Directed bench for alu_compare_seq at WIDTH=16, CHUNK=4.
// The expected values are worked out by hand from the slice-by-slice compare rule.
// Outputs are sampled 1ns after the rising edge, and inputs are driven on the falling edge.
module tb_alu_compare_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  Op = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  outp;
    logic        eq, gt, lt, busy;

    int errs   = 0;
    int checks = 0;

    alu_compare_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Op(Op), .sgn(sgn), .out_valid(out_valid),
        .out_ready(out_ready), .outp(outp), .eq(eq), .gt(gt), .lt(lt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for out_valid, then check the latency and the result. Leaves the result pending in DONE.
    task automatic wait_result(input string tag, input int exp_lat, input logic [2:0] exp_egl,
                               input logic [3:0] exp_outp);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_egl"}, {eq, gt, lt}, exp_egl);
        check({tag, "_outp"}, outp, exp_outp);
    endtask

    // Take the result and confirm that the outputs clear and the block returns to IDLE.
    task automatic take_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_clr"}, {out_valid, outp, eq, gt, lt, busy, in_ready}, 10'b0_0000_000_0_1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op, input logic s);
        @(negedge clk);
        A = a; B = b; Op = op; sgn = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] op, input logic s, input int exp_lat,
                          input logic [2:0] exp_egl, input logic [3:0] exp_outp);
        accept(a, b, op, s);
        wait_result(tag, exp_lat, exp_egl, exp_outp);
        take_result(tag);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_outs", {out_valid, outp, eq, gt, lt, busy, in_ready}, 10'b0_0000_000_0_1);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands walk all four slices. The flags are ordered {eq,gt,lt}.
        run_op("eq_1234",   16'h1234, 16'h1234, 4'b1001, 1'b0, 4, 3'b100, 4'b0001);
        run_op("ne_1234",   16'h1234, 16'h1234, 4'b1011, 1'b0, 4, 3'b100, 4'b0000);
        // Sign handling: the top slice decides at once.
        run_op("gt_u8000",  16'h8000, 16'h0001, 4'b1101, 1'b0, 1, 3'b010, 4'b0001);
        run_op("gt_s8000",  16'h8000, 16'h0001, 4'b1101, 1'b1, 1, 3'b001, 4'b0000);
        run_op("lt_s8000",  16'h8000, 16'h0001, 4'b1111, 1'b1, 1, 3'b001, 4'b0001);
        // The difference is only in the last slice.
        run_op("lt_1235",   16'h1235, 16'h1234, 4'b1111, 1'b0, 4, 3'b010, 4'b0000);
        run_op("ge_1235",   16'h1235, 16'h1234, 4'b1100, 1'b0, 4, 3'b010, 4'b0001);
        run_op("le_ffff",   16'hFFFF, 16'hFFFF, 4'b1110, 1'b0, 4, 3'b100, 4'b0001);
        // Invalid opcode: 3 vs 7 differ only in the lowest slice.
        run_op("inv_op",    16'h0003, 16'h0007, 4'b0101, 1'b0, 4, 3'b001, 4'b0000);

        // Backpressure: the result stays stable and the new operands are not taken.
        accept(16'h0A00, 16'h0500, 4'b1101, 1'b0);
        wait_result("bp", 2, 3'b010, 4'b0001);
        @(negedge clk);
        A = 16'h0005; B = 16'h0009; Op = 4'b1111; sgn = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {out_valid, outp, eq, gt, lt, in_ready, busy}, 10'b1_0001_010_0_1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_acc", {in_ready, busy}, 2'b01);
        in_valid = 1'b0;
        wait_result("bp_new", 4, 3'b001, 4'b0001);
        take_result("bp_new");

        // Asynchronous reset during the second COMPARE cycle.
        accept(16'h1234, 16'h1234, 4'b1001, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", {out_valid, outp, eq, gt, lt, busy, in_ready}, 10'b0_0000_000_0_1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst",  16'hFFFF, 16'h0000, 4'b1111, 1'b1, 1, 3'b001, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
